// File: rtl/chipper_pkg.sv
// Shared CHIPPER definitions: flit width, port indices and the port-loader state encoding.
package chipper_pkg;

    localparam int FLIT_W = 7;

    // Port indices; also the bit positions inside flit_valid.
    localparam int PORT_N = 3;
    localparam int PORT_S = 2;
    localparam int PORT_E = 1;
    localparam int PORT_W = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_N,
        ST_LD_S,
        ST_LD_E,
        ST_LD_W,
        ST_COMMIT,
        ST_DONE
    } loader_state_e;

endpackage

// File: rtl/chipper_port_loader_if.sv
// Signal bundle between the injection logic, the port loader and the CHIPPER router input side.
interface chipper_port_loader_if #(
    parameter int FLIT_W = chipper_pkg::FLIT_W
);
    // Handshake: a round is accepted on any rising edge where start=1 and ready=1;
    // ready is low from the cycle after accept until the cycle after done, and start
    // seen while ready=0 is dropped, never queued.
    logic              start;
    logic              ready;
    logic [3:0]        flit_valid;
    logic [FLIT_W-1:0] flit_n;
    logic [FLIT_W-1:0] flit_s;
    logic [FLIT_W-1:0] flit_e;
    logic [FLIT_W-1:0] flit_w;
    logic [FLIT_W-1:0] inc;
    logic              nsig;
    logic              ssig;
    logic              esig;
    logic              wsig;
    logic              clksig;
    logic              done;
    logic [7:0]        round_cnt;

    modport master (
        output start, flit_valid, flit_n, flit_s, flit_e, flit_w,
        input  ready, inc, nsig, ssig, esig, wsig, clksig, done, round_cnt
    );

    modport slave (
        input  start, flit_valid, flit_n, flit_s, flit_e, flit_w,
        output ready, inc, nsig, ssig, esig, wsig, clksig, done, round_cnt
    );

endinterface

// File: rtl/chipper_port_loader.sv
// Serialises one round of N/S/E/W flits onto the router's shared inc bus with
// per-port strobes held HOLD cycles, then issues a clksig commit and a done pulse.
module chipper_port_loader
    import chipper_pkg::*;
#(
    parameter int                FLIT_W     = chipper_pkg::FLIT_W,
    parameter int                HOLD       = 1,
    parameter logic [FLIT_W-1:0] EMPTY_FLIT = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chipper_port_loader_if.slave  lp,
    output loader_state_e         state
);

    if (HOLD < 1 || HOLD > 15) begin : g_hold_check
        $error("chipper_port_loader: HOLD must be within 1..15");
    end

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    loader_state_e     state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic              hold_end;
    logic [3:0]        vld_q;
    logic [FLIT_W-1:0] fn_q, fs_q, fe_q, fw_q;
    logic [FLIT_W-1:0] inc_q, inc_d;
    logic              ready_q;
    logic              nsig_q, ssig_q, esig_q, wsig_q;
    logic              clksig_q, done_q;
    logic [7:0]        cnt_q;
    logic              accept;

    function automatic logic [FLIT_W-1:0] slot(input logic v, input logic [FLIT_W-1:0] f);
        return v ? f : EMPTY_FLIT;
    endfunction

    assign hold_end = (hold_q == HOLD_LAST);
    assign accept   = (state_q == ST_IDLE) && lp.start;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                if (lp.start) begin
                    state_d = ST_LD_N;
                    hold_d  = '0;
                end
            end
            ST_LD_N, ST_LD_S, ST_LD_E, ST_LD_W: begin
                if (hold_end) begin
                    hold_d = '0;
                    unique case (state_q)
                        ST_LD_N: state_d = ST_LD_S;
                        ST_LD_S: state_d = ST_LD_E;
                        ST_LD_E: state_d = ST_LD_W;
                        default: state_d = ST_COMMIT;
                    endcase
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_COMMIT: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // inc is computed from the next state so it moves on the same edge as its strobe.
    // On the accept edge the latches are not yet loaded, so the N slot reads the inputs.
    always_comb begin
        inc_d = '0;
        case (state_d)
            ST_LD_N:   inc_d = (state_q == ST_IDLE) ? slot(lp.flit_valid[PORT_N], lp.flit_n)
                                                    : slot(vld_q[PORT_N], fn_q);
            ST_LD_S:   inc_d = slot(vld_q[PORT_S], fs_q);
            ST_LD_E:   inc_d = slot(vld_q[PORT_E], fe_q);
            ST_LD_W:   inc_d = slot(vld_q[PORT_W], fw_q);
            ST_COMMIT: inc_d = inc_q;
            default:   inc_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            inc_q    <= '0;
            ready_q  <= 1'b1;
            nsig_q   <= 1'b0;
            ssig_q   <= 1'b0;
            esig_q   <= 1'b0;
            wsig_q   <= 1'b0;
            clksig_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            inc_q    <= inc_d;
            ready_q  <= (state_d == ST_IDLE);
            nsig_q   <= (state_d == ST_LD_N);
            ssig_q   <= (state_d == ST_LD_S);
            esig_q   <= (state_d == ST_LD_E);
            wsig_q   <= (state_d == ST_LD_W);
            clksig_q <= (state_d == ST_COMMIT);
            done_q   <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            fn_q  <= '0;
            fs_q  <= '0;
            fe_q  <= '0;
            fw_q  <= '0;
        end else if (accept) begin
            vld_q <= lp.flit_valid;
            fn_q  <= lp.flit_n;
            fs_q  <= lp.flit_s;
            fe_q  <= lp.flit_e;
            fw_q  <= lp.flit_w;
        end
    end

    assign lp.ready     = ready_q;
    assign lp.inc       = inc_q;
    assign lp.nsig      = nsig_q;
    assign lp.ssig      = ssig_q;
    assign lp.esig      = esig_q;
    assign lp.wsig      = wsig_q;
    assign lp.clksig    = clksig_q;
    assign lp.done      = done_q;
    assign lp.round_cnt = cnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_chipper_port_loader.sv
// Bench for chipper_port_loader: HOLD=1 and HOLD=3 instances, expected-event queues
// filled by the drivers and drained by per-instance monitors on the falling edge.
module tb_chipper_port_loader;
    import chipper_pkg::*;

    // Event word: {cycle[31:0], nsig,ssig,esig,wsig, clksig,done, inc[6:0], round_cnt[7:0]}
    localparam int W = 53;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done1_cnt = 0;

    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q3[$];
    logic [7:0]   mcnt1 = 8'd0;
    logic [7:0]   mcnt3 = 8'd0;

    loader_state_e st1, st3;

    chipper_port_loader_if lp1();
    chipper_port_loader_if lp3();

    chipper_port_loader #(.FLIT_W(FLIT_W), .HOLD(1), .EMPTY_FLIT('0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .lp(lp1), .state(st1)
    );

    chipper_port_loader #(.FLIT_W(FLIT_W), .HOLD(3), .EMPTY_FLIT('0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .lp(lp3), .state(st3)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_ev(input int which, input logic [W-1:0] e);
        if (which == 1) exp_q1.push_back(e);
        else exp_q3.push_back(e);
    endtask

    // Expected events for a round accepted on the edge ending cycle c0; ports<4 models an aborted round.
    task automatic push_round(input int which, input int c0, input logic [3:0] v,
                              input logic [6:0] fn, input logic [6:0] fs,
                              input logic [6:0] fe, input logic [6:0] fw, input int ports);
        int h;
        logic [6:0] fl[4];
        logic [6:0] val;
        logic [7:0] cnt;
        h = (which == 1) ? 1 : 3;
        cnt = (which == 1) ? mcnt1 : mcnt3;
        fl[0] = fn; fl[1] = fs; fl[2] = fe; fl[3] = fw;
        for (int p = 0; p < ports; p++) begin
            val = v[3-p] ? fl[p] : 7'h00;
            for (int k = 0; k < h; k++)
                push_ev(which, {32'(c0 + 1 + p*h + k), 4'(8 >> p), 2'b00, val, cnt});
        end
        if (ports == 4) begin
            val = v[0] ? fw : 7'h00;
            push_ev(which, {32'(c0 + 4*h + 1), 4'b0000, 2'b10, val, cnt});
            cnt = cnt + 8'd1;
            push_ev(which, {32'(c0 + 4*h + 2), 4'b0000, 2'b01, 7'h00, cnt});
            if (which == 1) mcnt1 = cnt;
            else mcnt3 = cnt;
        end
    endtask

    task automatic set_flits1(input logic [3:0] v, input logic [6:0] fn, input logic [6:0] fs,
                              input logic [6:0] fe, input logic [6:0] fw);
        lp1.flit_valid = v; lp1.flit_n = fn; lp1.flit_s = fs; lp1.flit_e = fe; lp1.flit_w = fw;
    endtask

    task automatic set_flits3(input logic [3:0] v, input logic [6:0] fn, input logic [6:0] fs,
                              input logic [6:0] fe, input logic [6:0] fw);
        lp3.flit_valid = v; lp3.flit_n = fn; lp3.flit_s = fs; lp3.flit_e = fe; lp3.flit_w = fw;
    endtask

    // One isolated round on the HOLD=1 instance; flits are scrambled right after accept.
    task automatic round1(input logic [3:0] v, input logic [6:0] fn, input logic [6:0] fs,
                          input logic [6:0] fe, input logic [6:0] fw);
        int c0;
        c0 = cyc;
        check("ready1_before_accept", lp1.ready, 1'b1);
        set_flits1(v, fn, fs, fe, fw);
        lp1.start = 1'b1;
        push_round(1, c0, v, fn, fs, fe, fw, 4);
        @(negedge clk);
        lp1.start = 1'b0;
        set_flits1(4'hf, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
        wait_cycle(c0 + 7);
        check("round_cnt1_after_round", lp1.round_cnt, mcnt1);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [W-1:0] act;
        if (rst_n && (lp1.nsig || lp1.ssig || lp1.esig || lp1.wsig || lp1.clksig || lp1.done)) begin
            act = {32'(cyc), lp1.nsig, lp1.ssig, lp1.esig, lp1.wsig, lp1.clksig, lp1.done,
                   lp1.inc, lp1.round_cnt};
            if (exp_q1.size() == 0) check("unexpected_activity1", act, '0);
            else check("round_evt1", act, exp_q1.pop_front());
            if (lp1.done) done1_cnt++;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] act;
        if (rst_n && (lp3.nsig || lp3.ssig || lp3.esig || lp3.wsig || lp3.clksig || lp3.done)) begin
            act = {32'(cyc), lp3.nsig, lp3.ssig, lp3.esig, lp3.wsig, lp3.clksig, lp3.done,
                   lp3.inc, lp3.round_cnt};
            if (exp_q3.size() == 0) check("unexpected_activity3", act, '0);
            else check("round_evt3", act, exp_q3.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        lp1.start = 1'b0;
        lp3.start = 1'b0;
        set_flits1(4'h0, 7'h00, 7'h00, 7'h00, 7'h00);
        set_flits3(4'h0, 7'h00, 7'h00, 7'h00, 7'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ready1", lp1.ready, 1'b1);
        check("rst_ready3", lp3.ready, 1'b1);
        check("rst_inc1", lp1.inc, 7'h00);
        check("rst_strobes1", {lp1.nsig, lp1.ssig, lp1.esig, lp1.wsig}, 4'b0000);
        check("rst_clksig_done1", {lp1.clksig, lp1.done}, 2'b00);
        check("rst_round_cnt1", lp1.round_cnt, 8'd0);
        check("rst_state1", st1, ST_IDLE);
        repeat (5) @(negedge clk);
        check("idle_ready1", lp1.ready, 1'b1);
        check("idle_round_cnt3", lp3.round_cnt, 8'd0);

        // HOLD=1, all ports valid
        round1(4'b1111, 7'b0000101, 7'b1100001, 7'b0100100, 7'b1100100);
        check("round_cnt1_first", lp1.round_cnt, 8'd1);

        // Invalid N and E slots are still strobed with an empty flit
        round1(4'b0101, 7'b0111111, 7'b1010101, 7'b0011001, 7'b0100111);

        // HOLD=3 with start held: second accept exactly at the edge ending cycle c0+15
        c0 = cyc;
        set_flits3(4'b1111, 7'h11, 7'h22, 7'h33, 7'h44);
        lp3.start = 1'b1;
        push_round(3, c0, 4'b1111, 7'h11, 7'h22, 7'h33, 7'h44, 4);
        wait_cycle(c0 + 5);
        set_flits3(4'b1011, 7'h55, 7'h66, 7'h77, 7'h08);
        push_round(3, c0 + 15, 4'b1011, 7'h55, 7'h66, 7'h77, 7'h08, 4);
        wait_cycle(c0 + 14);
        check("ready3_busy", lp3.ready, 1'b0);
        wait_cycle(c0 + 15);
        check("ready3_back", lp3.ready, 1'b1);
        wait_cycle(c0 + 16);
        lp3.start = 1'b0;
        check("ready3_second_accept", lp3.ready, 1'b0);
        wait_cycle(c0 + 31);
        check("round_cnt3_two_rounds", lp3.round_cnt, 8'd2);

        // Reset asserted during LD_E abandons the round
        c0 = cyc;
        set_flits1(4'b1111, 7'h0a, 7'h0b, 7'h0c, 7'h0d);
        lp1.start = 1'b1;
        push_round(1, c0, 4'b1111, 7'h0a, 7'h0b, 7'h0c, 7'h0d, 2);
        @(negedge clk);
        lp1.start = 1'b0;
        wait_cycle(c0 + 2);
        @(posedge clk);
        #2;
        check("pre_rst_esig1", lp1.esig, 1'b1);
        rst_n = 1'b0;
        mcnt1 = 8'd0;
        mcnt3 = 8'd0;
        #1;
        check("midrst_strobes1", {lp1.nsig, lp1.ssig, lp1.esig, lp1.wsig}, 4'b0000);
        check("midrst_inc1", lp1.inc, 7'h00);
        check("midrst_clksig_done1", {lp1.clksig, lp1.done}, 2'b00);
        check("midrst_round_cnt1", lp1.round_cnt, 8'd0);
        check("midrst_state1", st1, ST_IDLE);
        check("midrst_round_cnt3", lp3.round_cnt, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("postrst_ready1", lp1.ready, 1'b1);
        round1(4'b1110, 7'h21, 7'h42, 7'h63, 7'h04);
        check("postrst_round_cnt1", lp1.round_cnt, 8'd1);

        // 256 back-to-back rounds from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        mcnt1 = 8'd0;
        mcnt3 = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        done1_cnt = 0;
        c0 = cyc;
        lp1.start = 1'b1;
        for (int k = 0; k < 256; k++) begin
            logic [6:0] a, b, c, d;
            wait_cycle(c0 + 7*k);
            a = 7'(k); b = 7'(k*3); c = ~7'(k); d = 7'(k + 5);
            set_flits1(4'(k), a, b, c, d);
            push_round(1, c0 + 7*k, 4'(k), a, b, c, d, 4);
        end
        wait_cycle(c0 + 7*255 + 1);
        lp1.start = 1'b0;
        wait_cycle(c0 + 7*256 + 1);
        check("wrap_round_cnt1", lp1.round_cnt, 8'd0);
        check("wrap_done_pulses1", done1_cnt, 256);
        check("wrap_ready1", lp1.ready, 1'b1);

        // Drain both scoreboards within a bounded window
        for (int i = 0; i < 50 && (exp_q1.size() != 0 || exp_q3.size() != 0); i++) @(negedge clk);
        check("queue_drain1", exp_q1.size(), 0);
        check("queue_drain3", exp_q3.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/chipper_port_loader.md
Name: chipper_port_loader

Overview:
- Drives the CHIPPER router's serial input-load interface: shared FLIT_W-bit bus inc, per-port strobes nsig/ssig/esig/wsig, then a one-cycle clksig commit pulse.
- Accepts one round of four parallel flits (N, S, E, W) through a ready/start handshake.
- Serialises the round onto inc in fixed order N, S, E, W, with each port's strobe held for HOLD cycles, then commits.
- Sits between the neighbour-link/injection logic and chipper, replacing hand-sequenced stimulus.

Parameters:
- FLIT_W, 7, flit width on inc and on the flit inputs.
- HOLD, 1, clock cycles each port strobe and its inc value are held (1..15).
- EMPTY_FLIT, 7'b0000000, value driven on inc for a port whose valid bit is 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to load a round; accepted only when ready=1.
- ready  out  1  high in IDLE.
- flit_valid  in  4  per-port valid: bit3=N, bit2=S, bit1=E, bit0=W.
- flit_n, flit_s, flit_e, flit_w  in  FLIT_W each  port flits, sampled on the accept cycle.
- inc  out  FLIT_W  flit bus to the router.
- nsig, ssig, esig, wsig  out  1 each  port load strobes.
- clksig  out  1  router commit pulse.
- done  out  1  one-cycle pulse when the round is complete.
- round_cnt  out  8  number of completed rounds; wraps from 255 to 0.

Behaviour:
- All outputs are registered. Reset values: inc=0, all strobes=0, clksig=0, done=0, round_cnt=0, ready=1, state=IDLE, hold counter=0.
- States: IDLE, LD_N, LD_S, LD_E, LD_W, COMMIT, DONE.
- Accept:
  - When state=IDLE and start=1 on an edge, latch the four flits and flit_valid, and move to LD_N.
  - ready falls in the cycle after accept.
- LD_x:
  - For HOLD cycles, the strobe of port x is 1 and inc = latched flit_x if valid_x, else EMPTY_FLIT.
  - The strobe and inc change together on the same edge. inc is stable for the whole strobe window.
  - Exactly one strobe is high at any time.
  - After HOLD cycles, advance N→S→E→W→COMMIT.
- Every port is strobed every round, even if invalid, so stale router latches are always overwritten.
- COMMIT:
  - Lasts 1 cycle: all strobes=0, clksig=1, inc holds the W value.
- DONE:
  - Lasts 1 cycle: clksig=0, done=1, round_cnt increments, inc returns to 0.
  - Next state is IDLE; ready=1 again in the following cycle.
- Timing, with accept edge = cycle 0:
  - nsig is high in cycles 1..HOLD.
  - clksig is high in cycle 4*HOLD+1.
  - done is high in cycle 4*HOLD+2.
  - The earliest next accept is the edge ending cycle 4*HOLD+3.
- start while busy is ignored; it is not queued.
- Flit inputs changing after accept have no effect on the current round.
- Reset mid-round: outputs drop asynchronously to reset values; the round is abandoned with no clksig or done; round_cnt is reset.
- HOLD counter width is 4 bits. HOLD=0 is illegal; an elaboration-time assertion rejects it.

Decomposition:
- Shared package chipper_pkg:
  - FLIT_W default.
  - State enum for this loader.
  - Port-index constants N=3, S=2, E=1, W=0 (also used by the router's output side).
- No sub-module is required. The hold counter stays inline.

Test Plan:
- Reset then idle → ready=1; inc, strobes, clksig, done and round_cnt all 0; no activity without start.
- HOLD=1, all valid, flits N=7'b0000101, S=7'b1100001, E=7'b0100100, W=7'b1100100, start at cycle 0:
  - nsig with inc=0000101 in cycle 1, ssig with 1100001 in cycle 2, esig with 0100100 in cycle 3, wsig with 1100100 in cycle 4.
  - clksig in cycle 5, done in cycle 6, round_cnt=1.
- flit_valid=4'b0101 with N=7'b0111111 and W=7'b0100111:
  - N and E slots drive 7'b0000000 with nsig/esig still pulsed; S and W slots drive their flits.
- HOLD=3, start held high continuously:
  - Each strobe is high for exactly 3 cycles; clksig in cycle 13, done in cycle 14.
  - The second accept occurs at the edge ending cycle 15 and no earlier.
  - Inputs changed during the round do not appear on inc.
- rst_n asserted during LD_E:
  - Outputs go to 0 immediately; no clksig; round_cnt=0; ready=1 after release.
  - A new start completes a normal round.
- 256 back-to-back rounds → round_cnt wraps to 0; done pulses exactly 256 times.
